// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared constants and types for the ARM-subset decode stage
package core_pkg;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_ORR = 3'd3;
  localparam logic [2:0] ALU_EOR = 3'd4;
  localparam logic [2:0] ALU_MUL = 3'd5;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_UND = 2'b11;

  localparam logic [3:0] MUL_I74 = 4'b1001;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_MULW = 1'b1;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       branch;
    logic       alu_src;
    logic       is_mul;
    logic [1:0] flag_write;
    logic [2:0] alu_ctrl;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decoder.sv
// rtl/ctrl_decoder.sv - combinational instruction-field to control-bundle mapping
module ctrl_decoder
  import core_pkg::*;
(
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [3:0] rd,
  input  logic [3:0] instr74,
  output ctrl_t      ctrl,
  output logic       pcsrc,
  output logic       illegal
);

  logic s_bit;
  logic is_mul;

  assign s_bit  = funct[0];
  assign is_mul = (op == OP_DP) && (funct[5:1] == 5'b00000) && (instr74 == MUL_I74);

  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    case (op)
      OP_DP: begin
        if (is_mul) begin
          ctrl.is_mul     = 1'b1;
          ctrl.reg_write  = 1'b1;
          ctrl.alu_ctrl   = ALU_MUL;
          ctrl.flag_write = {s_bit, 1'b0};
        end else begin
          ctrl.alu_src   = funct[5];
          ctrl.reg_write = 1'b1;
          case (funct[4:1])
            CMD_ADD: begin ctrl.alu_ctrl = ALU_ADD; ctrl.flag_write = {s_bit, s_bit}; end
            CMD_SUB: begin ctrl.alu_ctrl = ALU_SUB; ctrl.flag_write = {s_bit, s_bit}; end
            CMD_AND: begin ctrl.alu_ctrl = ALU_AND; ctrl.flag_write = {s_bit, 1'b0}; end
            CMD_ORR: begin ctrl.alu_ctrl = ALU_ORR; ctrl.flag_write = {s_bit, 1'b0}; end
            CMD_EOR: begin ctrl.alu_ctrl = ALU_EOR; ctrl.flag_write = {s_bit, 1'b0}; end
            // CMP is a flag-only SUB, so S is implied regardless of the encoded bit
            CMD_CMP: begin
              ctrl.alu_ctrl   = ALU_SUB;
              ctrl.reg_write  = 1'b0;
              ctrl.flag_write = 2'b11;
            end
            default: begin
              ctrl    = '0;
              illegal = 1'b1;
            end
          endcase
        end
      end
      OP_MEM: begin
        ctrl.alu_src    = 1'b1;
        ctrl.alu_ctrl   = funct[3] ? ALU_ADD : ALU_SUB;
        ctrl.reg_write  = funct[0];
        ctrl.mem_to_reg = funct[0];
        ctrl.mem_write  = ~funct[0];
      end
      OP_BR: begin
        ctrl.branch    = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_ctrl  = ALU_ADD;
        ctrl.reg_write = funct[4];
      end
      default: illegal = 1'b1;
    endcase
  end

  assign pcsrc = ((rd == 4'd15) && ctrl.reg_write && !ctrl.branch) || ctrl.branch;

endmodule

// File: rtl/decode_pipe.sv
// rtl/decode_pipe.sv - decode stage with D/E pipeline register and multi-cycle MUL occupancy
module decode_pipe
  import core_pkg::*;
#(
  parameter int ALUCTRL_W = 3,
  parameter int MUL_LAT   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 validD,
  input  logic [1:0]           Op,
  input  logic [5:0]           Funct,
  input  logic [3:0]           Rd,
  input  logic [3:0]           Instr74,
  input  logic                 stall_i,
  input  logic                 flush_i,
  output logic                 readyD,
  output logic [1:0]           ImmSrcD,
  output logic [1:0]           RegSrcD,
  output logic                 illegalD,
  output logic                 validE,
  output logic                 PCSrcE,
  output logic                 RegWriteE,
  output logic                 MemtoRegE,
  output logic                 MemWriteE,
  output logic                 BranchE,
  output logic                 ALUSrcE,
  output logic                 MulE,
  output logic [ALUCTRL_W-1:0] ALUControlE,
  output logic [1:0]           FlagWriteE
);

  localparam int CW = $clog2(MUL_LAT + 1);

  ctrl_t          dec_ctrl;
  logic           dec_pcsrc;
  logic           dec_illegal;
  logic           take;
  logic           mul_busy;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic           valid_q;
  logic           pcsrc_q;
  ctrl_t          ctrl_q;

  ctrl_decoder u_dec (
    .op      (Op),
    .funct   (Funct),
    .rd      (Rd),
    .instr74 (Instr74),
    .ctrl    (dec_ctrl),
    .pcsrc   (dec_pcsrc),
    .illegal (dec_illegal)
  );

  assign ImmSrcD  = Op;
  assign RegSrcD  = {(Op == OP_MEM), (Op == OP_BR)};
  assign illegalD = validD & dec_illegal;
  assign take     = validD & ~dec_illegal;
  assign mul_busy = (state == ST_MULW);
  assign readyD   = (state == ST_IDLE) & ~stall_i;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      valid_q <= 1'b0;
      pcsrc_q <= 1'b0;
      ctrl_q  <= '0;
    end else if (flush_i) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      valid_q <= 1'b0;
      pcsrc_q <= 1'b0;
      ctrl_q  <= '0;
    end else if (!stall_i) begin
      if (state == ST_IDLE) begin
        valid_q <= take;
        pcsrc_q <= take & dec_pcsrc;
        ctrl_q  <= take ? dec_ctrl : '0;
        if (take && dec_ctrl.is_mul && (MUL_LAT > 1)) begin
          state <= ST_MULW;
          cnt   <= CW'(MUL_LAT - 1);
        end
      end else begin
        // E keeps the MUL; the final occupancy cycle is the first one back in IDLE
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state <= ST_IDLE;
        end
      end
    end
  end

  assign validE      = valid_q;
  assign PCSrcE      = pcsrc_q;
  assign MemtoRegE   = ctrl_q.mem_to_reg;
  assign MemWriteE   = ctrl_q.mem_write;
  assign BranchE     = ctrl_q.branch;
  assign ALUSrcE     = ctrl_q.alu_src;
  assign MulE        = ctrl_q.is_mul;
  assign ALUControlE = ALUCTRL_W'(ctrl_q.alu_ctrl);
  // A MUL still occupying execute must not commit its result or flags yet
  assign RegWriteE   = ctrl_q.reg_write & ~mul_busy;
  assign FlagWriteE  = ctrl_q.flag_write & {2{~mul_busy}};

endmodule

// File: tb/tb_decode_pipe.sv
// tb/tb_decode_pipe.sv - scoreboard bench for decode_pipe
module tb_decode_pipe;

  logic       clk = 1'b0;
  logic       reset;
  logic       validD;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] Instr74;
  logic       stall_i;
  logic       flush_i;
  logic       readyD;
  logic [1:0] ImmSrcD;
  logic [1:0] RegSrcD;
  logic       illegalD;
  logic       validE, PCSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE, MulE;
  logic [2:0] ALUControlE;
  logic [1:0] FlagWriteE;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [12:0] exp;
  } sb_t;
  sb_t sb[$];

  logic [12:0] e_vec;
  assign e_vec = {validE, PCSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE, MulE,
                  FlagWriteE, ALUControlE};

  decode_pipe #(.ALUCTRL_W(3), .MUL_LAT(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .validD      (validD),
    .Op          (Op),
    .Funct       (Funct),
    .Rd          (Rd),
    .Instr74     (Instr74),
    .stall_i     (stall_i),
    .flush_i     (flush_i),
    .readyD      (readyD),
    .ImmSrcD     (ImmSrcD),
    .RegSrcD     (RegSrcD),
    .illegalD    (illegalD),
    .validE      (validE),
    .PCSrcE      (PCSrcE),
    .RegWriteE   (RegWriteE),
    .MemtoRegE   (MemtoRegE),
    .MemWriteE   (MemWriteE),
    .BranchE     (BranchE),
    .ALUSrcE     (ALUSrcE),
    .MulE        (MulE),
    .ALUControlE (ALUControlE),
    .FlagWriteE  (FlagWriteE)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] ev(input logic v, input logic pc, input logic rw, input logic m2r,
                                     input logic mw, input logic br, input logic as, input logic mul,
                                     input logic [1:0] fw, input logic [2:0] alu);
    return {v, pc, rw, m2r, mw, br, as, mul, fw, alu};
  endfunction

  // one clock: drive D inputs, check readyD, queue the E state expected after the edge
  task automatic cyc(input string tag, input logic v, input logic [1:0] op, input logic [5:0] fn,
                     input logic [3:0] rd, input logic [3:0] i74, input logic st, input logic fl,
                     input logic exp_rdy, input logic [12:0] exp_e);
    sb_t item;
    validD = v; Op = op; Funct = fn; Rd = rd; Instr74 = i74; stall_i = st; flush_i = fl;
    #1;
    chk({tag, ".rdy"}, {31'd0, readyD}, {31'd0, exp_rdy});
    sb.push_back('{tag: tag, exp: exp_e});
    @(posedge clk);
    @(negedge clk);
    item = sb.pop_front();
    chk(item.tag, {19'd0, e_vec}, {19'd0, item.exp});
  endtask

  logic [12:0] bub, e_add, e_mulm, e_mulf;

  initial begin
    bub    = '0;
    e_add  = ev(1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 3'd0);
    e_mulm = ev(1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'd5);
    e_mulf = ev(1, 0, 1, 0, 0, 0, 0, 1, 2'b10, 3'd5);

    reset = 1'b0; validD = 0; Op = 0; Funct = 0; Rd = 0; Instr74 = 0; stall_i = 0; flush_i = 0;
    repeat (2) @(negedge clk);
    chk("reset.e", {19'd0, e_vec}, 32'd0);
    chk("reset.rdy", {31'd0, readyD}, 32'd1);
    reset = 1'b1;

    cyc("add_s",  1, 2'b00, 6'b001001, 4'd3,  4'd0, 0, 0, 1, ev(1,0,1,0,0,0,0,0,2'b11,3'd0));
    cyc("eor_pc", 1, 2'b00, 6'b000010, 4'd15, 4'd0, 0, 0, 1, ev(1,1,1,0,0,0,0,0,2'b00,3'd4));
    chk("eor.immsrc", {30'd0, ImmSrcD}, 32'd0);
    chk("eor.regsrc", {30'd0, RegSrcD}, 32'd0);
    cyc("cmp",    1, 2'b00, 6'b010100, 4'd0,  4'd0, 0, 0, 1, ev(1,0,0,0,0,0,0,0,2'b11,3'd1));
    cyc("orr_i",  1, 2'b00, 6'b111000, 4'd1,  4'd0, 0, 0, 1, ev(1,0,1,0,0,0,1,0,2'b00,3'd3));
    cyc("sub_pc", 1, 2'b00, 6'b000101, 4'd15, 4'd0, 0, 0, 1, ev(1,1,1,0,0,0,0,0,2'b11,3'd1));
    cyc("ldr",    1, 2'b01, 6'b011001, 4'd2,  4'd0, 0, 0, 1, ev(1,0,1,1,0,0,1,0,2'b00,3'd0));
    chk("ldr.immsrc", {30'd0, ImmSrcD}, 32'd1);
    chk("ldr.regsrc", {30'd0, RegSrcD}, 32'd2);
    cyc("str",    1, 2'b01, 6'b010000, 4'd2,  4'd0, 0, 0, 1, ev(1,0,0,0,1,0,1,0,2'b00,3'd1));
    cyc("bl",     1, 2'b10, 6'b010000, 4'd0,  4'd0, 0, 0, 1, ev(1,1,1,0,0,1,1,0,2'b00,3'd0));
    chk("bl.regsrc", {30'd0, RegSrcD}, 32'd1);
    cyc("op11",   1, 2'b11, 6'b001000, 4'd1,  4'd0, 0, 0, 1, bub);
    chk("op11.illegal", {31'd0, illegalD}, 32'd1);
    cyc("badcmd", 1, 2'b00, 6'b000110, 4'd1,  4'd0, 0, 0, 1, bub);
    chk("badcmd.illegal", {31'd0, illegalD}, 32'd1);
    cyc("novalid",0, 2'b00, 6'b001000, 4'd5,  4'd0, 0, 0, 1, bub);
    chk("novalid.illegal", {31'd0, illegalD}, 32'd0);

    cyc("mul.c1", 1, 2'b00, 6'b000001, 4'd4, 4'b1001, 0, 0, 1, e_mulm);
    cyc("mul.c2", 1, 2'b00, 6'b001000, 4'd5, 4'd0, 0, 0, 0, e_mulm);
    cyc("mul.c3", 1, 2'b00, 6'b001000, 4'd5, 4'd0, 0, 0, 0, e_mulf);
    cyc("mul.add",1, 2'b00, 6'b001000, 4'd5, 4'd0, 0, 0, 1, e_add);

    cyc("fl.mul", 1, 2'b00, 6'b000001, 4'd4, 4'b1001, 0, 0, 1, e_mulm);
    cyc("fl.fl",  1, 2'b00, 6'b001000, 4'd5, 4'd0, 0, 1, 0, bub);
    cyc("fl.add", 1, 2'b00, 6'b001000, 4'd5, 4'd0, 0, 0, 1, e_add);
    cyc("st_fl",  1, 2'b00, 6'b001000, 4'd5, 4'd0, 1, 1, 0, bub);

    cyc("st.mul", 1, 2'b00, 6'b000001, 4'd4, 4'b1001, 0, 0, 1, e_mulm);
    cyc("st.s1",  1, 2'b00, 6'b001000, 4'd5, 4'd0, 1, 0, 0, e_mulm);
    cyc("st.s2",  1, 2'b00, 6'b001000, 4'd5, 4'd0, 1, 0, 0, e_mulm);
    cyc("st.c2",  1, 2'b00, 6'b001000, 4'd5, 4'd0, 0, 0, 0, e_mulm);
    cyc("st.c3",  1, 2'b00, 6'b001000, 4'd5, 4'd0, 0, 0, 0, e_mulf);
    cyc("st.add", 1, 2'b00, 6'b001000, 4'd5, 4'd0, 0, 0, 1, e_add);
    cyc("st.idle",1, 2'b00, 6'b000010, 4'd15,4'd0, 1, 0, 0, e_add);

    cyc("b2b.m1", 1, 2'b00, 6'b000001, 4'd4, 4'b1001, 0, 0, 1, e_mulm);
    cyc("b2b.w1", 1, 2'b00, 6'b000001, 4'd4, 4'b1001, 0, 0, 0, e_mulm);
    cyc("b2b.w2", 1, 2'b00, 6'b000001, 4'd4, 4'b1001, 0, 0, 0, e_mulf);
    cyc("b2b.m2", 1, 2'b00, 6'b000001, 4'd4, 4'b1001, 0, 0, 1, e_mulm);

    #3;
    reset = 1'b0;
    #1;
    chk("arst.e", {19'd0, e_vec}, 32'd0);
    chk("arst.rdy", {31'd0, readyD}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    cyc("arst.add", 1, 2'b00, 6'b001000, 4'd5, 4'd0, 0, 0, 1, e_add);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_pipe.md
# decode_pipe

Parametrised decode stage for the pipelined ARM-subset core. It decodes the D-stage instruction fields into control signals and registers them into the D/E pipeline boundary with stall and flush. It adds EOR, CMP, BL and a multi-cycle MUL whose occupancy is tracked by an internal FSM that back-pressures fetch. It sits between the fetch/IF-ID register and the execute datapath, beside the hazard unit.

## Interface
- `ALUCTRL_W`, 3: width of the ALU control code; must be at least 3.
- `MUL_LAT`, 3: cycles a MUL occupies execute; must be at least 1.
- `clk`  in  1  core clock.
- `reset`  in  1  asynchronous, active-low reset.
- `validD`  in  1  D-stage instruction is valid.
- `Op`  in  2  instr[27:26].
- `Funct`  in  6  instr[25:20].
- `Rd`  in  4  instr[15:12].
- `Instr74`  in  4  instr[7:4]; MUL when `Op`=00, `Funct[5:1]`=00000 and `Instr74`=1001.
- `stall_i`  in  1  hazard-unit stall.
- `flush_i`  in  1  hazard-unit flush.
- `readyD`  out  1  D stage may advance.
- `ImmSrcD`  out  2  combinational; equals `Op`.
- `RegSrcD`  out  2  combinational; [0]=(`Op`==10), [1]=(`Op`==01).
- `illegalD`  out  1  combinational; valid instruction with undefined encoding.
- `validE`, `PCSrcE`, `RegWriteE`, `MemtoRegE`, `MemWriteE`, `BranchE`, `ALUSrcE`, `MulE`  out  1 each  registered E-stage controls.
- `ALUControlE`  out  `ALUCTRL_W`  registered ALU code.
- `FlagWriteE`  out  2  registered; [1]=NZ, [0]=CV.

## Operation
- ALU codes: ADD 0, SUB 1, AND 2, ORR 3, EOR 4, MUL 5.
- Data processing (`Op`=00):
  - cmd=`Funct[4:1]`: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 0001 EOR, 1010 CMP.
  - CMP uses SUB, sets `RegWriteE`=0 and forces S=1.
  - `ALUSrcE`=`Funct[5]`.
  - `FlagWriteE[1]`=S. `FlagWriteE[0]`=S and (ADD, SUB or CMP).
- Memory (`Op`=01): `ALUSrcE`=1. ALU=ADD if `Funct[3]`, otherwise SUB. `RegWriteE`=`MemtoRegE`=`Funct[0]`, `MemWriteE`=~`Funct[0]`.
- Branch (`Op`=10): `BranchE`=1, `ALUSrcE`=1, ALU=ADD. `RegWriteE`=`Funct[4]` (BL writes R14).
- `PCSrcE` = (`Rd`==15 and `RegWrite` and not branch) or branch.
- `Op`=11 or an unlisted cmd is illegal: `illegalD`=1 and a bubble is registered.
- Bubble: `validE` and every write/branch control is 0, `ALUControlE`=0.
- FSM states are IDLE and MULW. Down-counter width is clog2(`MUL_LAT`+1).
- IDLE:
  - A valid MUL is registered with `MulE`=1.
  - If `MUL_LAT`>1: go to MULW and load counter = `MUL_LAT`−1.
- MULW:
  - E register holds the MUL and `readyD`=0.
  - Counter decrements each non-stalled cycle.
  - Reaching 0 returns to IDLE.
- `RegWriteE` and `FlagWriteE` of a MUL are asserted only in its final occupancy cycle; they are 0 in earlier cycles.
- `readyD` = (state==IDLE) and not `stall_i`.

## Timing
- Reset: all E outputs 0, state IDLE, counter 0, `readyD`=1 once `stall_i`=0.
- Decode-to-E latency is 1 cycle. D-side outputs are combinational.
- `stall_i`: E register, FSM and counter all hold.
- `flush_i`: E register loads a bubble and the FSM returns to IDLE with counter 0, aborting any MUL.
- `flush_i` wins over `stall_i` when both are asserted.
- `validD`=0 registers a bubble.
- With `MUL_LAT`=1, a MUL behaves as a single-cycle op: no MULW, write-enables set in its only cycle.
- Back-to-back MULs: the second waits in D until the first's final cycle, then registers on the next edge.
- Reset asserted mid-MUL returns everything to reset values asynchronously.

## Structure
- Shared package `core_pkg`:
  - ALU code constants (`ALU_ADD`..`ALU_MUL`).
  - cmd encodings.
  - `Op` class constants.
  - The FSM state typedef.
- One sub-module, `ctrl_decoder`: pure combinational mapping of `Op`/`Funct`/`Rd`/`Instr74` to the control bundle and the illegal flag.
- Top level holds the E register, FSM, counter and `RegWrite`/`FlagWrite` masking.

## Test plan
- Reset, then ADD with S=1 (`Op`=00, `Funct`=001001, `Rd`=3) → next cycle `validE`=1, `ALUControlE`=0, `RegWriteE`=1, `FlagWriteE`=11, `PCSrcE`=0.
- EOR with `Rd`=15 and S=0 → `ALUControlE`=4, `PCSrcE`=1, `FlagWriteE`=00. CMP → `ALUControlE`=1, `RegWriteE`=0, `FlagWriteE`=11.
- MUL with `MUL_LAT`=3:
  - `MulE`=1 for 3 cycles; `readyD`=0 in the last 2.
  - `RegWriteE`=1 only in cycle 3; a following ADD reaches E in cycle 4.
- `flush_i` in the second MUL cycle → bubble next cycle, state IDLE, `readyD`=1. `stall_i` and `flush_i` together → bubble.
- `stall_i` held 2 cycles mid-MUL → E outputs and counter frozen; MUL completes 2 cycles later.
- BL (`Op`=10, `Funct[4]`=1) → `BranchE`=1, `RegWriteE`=1, `PCSrcE`=1. `Op`=11 → `illegalD`=1 and bubble registered.
